// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding and mode bit positions.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL
    } spi_state_t;

    localparam int unsigned CPOL_BIT = 1;
    localparam int unsigned CPHA_BIT = 0;

endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer: tick is high in the last clk cycle of every SPI half-period.
module spi_clkgen #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] div_in,
    output logic             tick,
    output logic             tick_next
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            div_q <= '0;
        end else if (load) begin
            cnt   <= '0;
            div_q <= div_in;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    assign tick = run && (cnt == div_q);

    // cnt < div_q whenever tick is low, so cnt+1 cannot wrap even at the maximum divider
    assign tick_next = tick ? (div_q == '0) : (cnt + DIV_W'(1) == div_q);

endmodule

// File: rtl/spi_master.sv
// SPI master: one DATA_W-bit full-duplex transfer per accepted start, modes 0-3,
// selectable bit order, SPI half-period of clkdiv+1 clk cycles.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic [DIV_W-1:0]  clkdiv,
    input  logic [1:0]        mode,
    input  logic              lsb_first,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              busy,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_cs_n
);

    localparam int unsigned HALVES = 2 * DATA_W;
    localparam int unsigned HC_W   = $clog2(HALVES);
    localparam logic [HC_W-1:0] LAST_HALF = HC_W'(HALVES - 1);

    spi_state_t        state;
    logic [HC_W-1:0]   hcnt;
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] rx;
    logic              cpha_q;
    logic              lsb_q;

    logic              tick;
    logic              tick_next;
    logic              last_half;
    logic              tx_bit;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic              din_first;
    logic [DATA_W-1:0] din_shift;

    assign last_half = (hcnt == LAST_HALF);
    assign tx_bit    = lsb_q ? tx[0] : tx[DATA_W-1];
    assign tx_shift  = lsb_q ? (tx >> 1) : (tx << 1);
    assign rx_shift  = lsb_q ? {spi_miso, rx[DATA_W-1:1]} : {rx[DATA_W-2:0], spi_miso};
    assign din_first = lsb_first ? din[0] : din[DATA_W-1];
    assign din_shift = lsb_first ? (din >> 1) : (din << 1);

    spi_clkgen #(
        .DIV_W(DIV_W)
    ) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == IDLE && start),
        .run      (state != IDLE),
        .div_in   (clkdiv),
        .tick     (tick),
        .tick_next(tick_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hcnt     <= '0;
            tx       <= '0;
            rx       <= '0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            dout     <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    spi_clk <= mode[CPOL_BIT];
                    if (start) begin
                        state    <= LEAD;
                        busy     <= 1'b1;
                        spi_cs_n <= 1'b0;
                        cpha_q   <= mode[CPHA_BIT];
                        lsb_q    <= lsb_first;
                        rx       <= '0;
                        hcnt     <= '0;
                        if (mode[CPHA_BIT]) begin
                            tx       <= din;
                            spi_mosi <= 1'b0;
                        end else begin
                            tx       <= din_shift;
                            spi_mosi <= din_first;
                        end
                    end
                end
                LEAD: begin
                    if (tick) state <= XFER;
                end
                XFER: begin
                    if (tick) begin
                        spi_clk <= ~spi_clk;
                        // even halves end on a leading edge, odd halves on a trailing edge
                        if (hcnt[0] == cpha_q) begin
                            rx <= rx_shift;
                        end else if (!last_half) begin
                            spi_mosi <= tx_bit;
                            tx       <= tx_shift;
                        end
                        if (last_half) begin
                            state <= TRAIL;
                            hcnt  <= '0;
                            if (tick_next) done <= 1'b1;
                        end else begin
                            hcnt <= hcnt + HC_W'(1);
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        spi_cs_n <= 1'b1;
                        dout     <= rx;
                    end else if (tick_next) begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
